// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared types and constants for the UART receive path
// Revision : 1.0
// ============================================================================
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  localparam logic [7:0] CMD_PLUS_1  = 8'h2B;  // '+'
  localparam logic [7:0] CMD_PLUS_5  = 8'h3E;  // '>'
  localparam logic [7:0] CMD_MINUS_1 = 8'h2D;  // '-'
  localparam logic [7:0] CMD_MINUS_5 = 8'h3C;  // '<'
  localparam logic [7:0] CMD_RESET_U = 8'h52;  // 'R'
  localparam logic [7:0] CMD_RESET_L = 8'h72;  // 'r'

endpackage
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// uart_rx : 8N1 receiver with input synchronizer, frame/break handling
// Revision : 1.0
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_frame_err,
  output logic       o_byte_strobe,
  output logic [7:0] o_byte_data
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] c_half_m1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] c_full_m1 = CNT_W'(CLKS_PER_BIT - 1);

  logic             r_sync1;
  logic             r_sync2;
  rx_state_t        r_state;
  rx_state_t        w_state_next;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_rx_data;
  logic             r_rx_valid;
  logic             r_frame_err;
  logic             w_tick;
  logic             w_timing;
  logic             w_good_stop;
  logic             w_bad_stop;

  assign w_timing = (r_state == ST_START) || (r_state == ST_DATA) || (r_state == ST_STOP);

  // Start bit is sampled at its middle; later bits a full period apart.
  assign w_tick = ((r_state == ST_START) && (r_clk_cnt == c_half_m1)) ||
                  (((r_state == ST_DATA) || (r_state == ST_STOP)) && (r_clk_cnt == c_full_m1));

  always_comb begin
    w_state_next = r_state;
    w_good_stop  = 1'b0;
    w_bad_stop   = 1'b0;
    case (r_state)
      ST_IDLE:  if (!r_sync2) w_state_next = ST_START;
      ST_START: if (w_tick) w_state_next = r_sync2 ? ST_IDLE : ST_DATA;
      ST_DATA:  if (w_tick && (r_bit_idx == 3'd7)) w_state_next = ST_STOP;
      ST_STOP: begin
        if (w_tick) begin
          if (r_sync2) begin
            w_good_stop  = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_bad_stop   = 1'b1;
            w_state_next = ST_BREAK;
          end
        end
      end
      ST_BREAK: if (r_sync2) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_state     <= ST_IDLE;
      r_clk_cnt   <= '0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync1     <= i_uart_rx;
      r_sync2     <= r_sync1;
      r_state     <= w_state_next;
      r_rx_valid  <= w_good_stop;
      r_frame_err <= w_bad_stop;

      if (w_good_stop) r_rx_data <= r_shift;

      if (w_tick || !w_timing) r_clk_cnt <= '0;
      else                     r_clk_cnt <= r_clk_cnt + CNT_W'(1);

      if (r_state == ST_IDLE) begin
        r_bit_idx <= 3'd0;
      end else if ((r_state == ST_DATA) && w_tick) begin
        r_bit_idx <= r_bit_idx + 3'd1;
        r_shift   <= {r_sync2, r_shift[7:1]};
      end
    end
  end

  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_frame_err   = r_frame_err;
  assign o_byte_strobe = w_good_stop;
  assign o_byte_data   = r_shift;

endmodule
`default_nettype wire

// File: rtl/uart_cmd_rx.sv
`default_nettype none
// ============================================================================
// uart_cmd_rx : UART receiver decoding ASCII bytes into one-cycle command pulses
// Revision : 1.0
// ============================================================================
module uart_cmd_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_frame_err,
  output logic       o_btn_plus_1,
  output logic       o_btn_plus_5,
  output logic       o_btn_minus_1,
  output logic       o_btn_minus_5,
  output logic       o_btn_reset
);

  logic       w_byte_strobe;
  logic [7:0] w_byte_data;
  logic       r_plus_1;
  logic       r_plus_5;
  logic       r_minus_1;
  logic       r_minus_5;
  logic       r_reset;

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_rx (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_uart_rx     (i_uart_rx),
    .o_rx_data     (o_rx_data),
    .o_rx_valid    (o_rx_valid),
    .o_frame_err   (o_frame_err),
    .o_byte_strobe (w_byte_strobe),
    .o_byte_data   (w_byte_data)
  );

  // Decoding the pre-register strobe lines the pulses up with o_rx_valid.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_plus_1  <= 1'b0;
      r_plus_5  <= 1'b0;
      r_minus_1 <= 1'b0;
      r_minus_5 <= 1'b0;
      r_reset   <= 1'b0;
    end else begin
      r_plus_1  <= w_byte_strobe && (w_byte_data == CMD_PLUS_1);
      r_plus_5  <= w_byte_strobe && (w_byte_data == CMD_PLUS_5);
      r_minus_1 <= w_byte_strobe && (w_byte_data == CMD_MINUS_1);
      r_minus_5 <= w_byte_strobe && (w_byte_data == CMD_MINUS_5);
      r_reset   <= w_byte_strobe &&
                   ((w_byte_data == CMD_RESET_U) || (w_byte_data == CMD_RESET_L));
    end
  end

  assign o_btn_plus_1  = r_plus_1;
  assign o_btn_plus_5  = r_plus_5;
  assign o_btn_minus_1 = r_minus_1;
  assign o_btn_minus_5 = r_minus_5;
  assign o_btn_reset   = r_reset;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_rx.sv
`default_nettype none
// ============================================================================
// tb_uart_cmd_rx : serial-frame stimulus against a byte-level command model
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_uart_cmd_rx;

  localparam int CPB  = 434;
  localparam int HALF = CPB / 2;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       b_p1, b_p5, b_m1, b_m5, b_rst;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [7:0] q_data[$];
  logic [4:0] q_btn[$];
  int         q_cyc[$];
  int         ferr_cnt  = 0;
  int         stray_cnt = 0;
  logic [7:0] last_good = 8'h00;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_uart_rx     (uart_rx),
    .o_rx_data     (rx_data),
    .o_rx_valid    (rx_valid),
    .o_frame_err   (frame_err),
    .o_btn_plus_1  (b_p1),
    .o_btn_plus_5  (b_p5),
    .o_btn_minus_1 (b_m1),
    .o_btn_minus_5 (b_m5),
    .o_btn_reset   (b_rst)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rx_valid) begin
      q_data.push_back(rx_data);
      q_btn.push_back({b_rst, b_m5, b_m1, b_p5, b_p1});
      q_cyc.push_back(cyc);
    end
    if (frame_err) ferr_cnt++;
    if (!rx_valid && ({b_rst, b_m5, b_m1, b_p5, b_p1} != 5'b0)) stray_cnt++;
  end

  // Reference command table: {reset, minus_5, minus_1, plus_5, plus_1}
  function automatic logic [4:0] exp_btn(input logic [7:0] b);
    case (b)
      8'h2B:        return 5'b00001;
      8'h3E:        return 5'b00010;
      8'h2D:        return 5'b00100;
      8'h3C:        return 5'b01000;
      8'h52, 8'h72: return 5'b10000;
      default:      return 5'b00000;
    endcase
  endfunction

  task automatic clear_mon();
    q_data.delete();
    q_btn.delete();
    q_cyc.delete();
    ferr_cnt  = 0;
    stray_cnt = 0;
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; returns on a negedge exactly 10 bit periods later.
  task automatic send_frame(input logic [7:0] b, input logic stop, output int t_start);
    uart_rx = 1'b0;
    t_start = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({rx_data, rx_valid, frame_err, b_p1, b_p5, b_m1, b_m5, b_rst} !== 15'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got data=%h v=%b fe=%b btn=%b%b%b%b%b, want all 0",
               rx_data, rx_valid, frame_err, b_rst, b_m5, b_m1, b_p5, b_p1);
    end
    reset_n = 1'b1;
    clear_mon();
    idle(10);
    n_cmp++;
    if (q_data.size() != 0 || ferr_cnt != 0 || stray_cnt != 0) begin
      n_bad++;
      $display("FAIL reset_quiet: got valid=%0d ferr=%0d stray=%0d, want 0/0/0",
               q_data.size(), ferr_cnt, stray_cnt);
    end
  endtask

  task automatic test_basic();
    int t;
    clear_mon();
    send_frame(8'h2B, 1'b1, t);
    idle(4);
    last_good = 8'h2B;
    n_cmp++;
    if (q_data.size() != 1) begin
      n_bad++;
      $display("FAIL basic_count: got %0d valid pulses, want 1", q_data.size());
    end else begin
      n_cmp++;
      if (q_data[0] !== 8'h2B) begin
        n_bad++;
        $display("FAIL basic_data: got %h want 2b", q_data[0]);
      end
      n_cmp++;
      if (q_btn[0] !== exp_btn(8'h2B)) begin
        n_bad++;
        $display("FAIL basic_btn: got %b want %b", q_btn[0], exp_btn(8'h2B));
      end
      n_cmp++;
      if (q_cyc[0] != t + HALF + 9 * CPB + 3) begin
        n_bad++;
        $display("FAIL basic_latency: got cycle %0d want %0d", q_cyc[0], t + HALF + 9 * CPB + 3);
      end
    end
    n_cmp++;
    if (rx_data !== 8'h2B || ferr_cnt != 0 || stray_cnt != 0) begin
      n_bad++;
      $display("FAIL basic_hold: got data=%h ferr=%0d stray=%0d want 2b/0/0",
               rx_data, ferr_cnt, stray_cnt);
    end
  endtask

  task automatic test_bytes(input string name, input logic [7:0] bytes[$]);
    int t;
    clear_mon();
    foreach (bytes[k]) send_frame(bytes[k], 1'b1, t);
    idle(4);
    if (bytes.size() > 0) last_good = bytes[bytes.size() - 1];
    n_cmp++;
    if (q_data.size() != bytes.size() || ferr_cnt != 0 || stray_cnt != 0) begin
      n_bad++;
      $display("FAIL %s_count: got valid=%0d ferr=%0d stray=%0d want %0d/0/0",
               name, q_data.size(), ferr_cnt, stray_cnt, bytes.size());
    end
    for (int i = 0; i < q_data.size() && i < bytes.size(); i++) begin
      n_cmp++;
      if (q_data[i] !== bytes[i] || q_btn[i] !== exp_btn(bytes[i])) begin
        n_bad++;
        $display("FAIL %s_byte%0d: got data=%h btn=%b want data=%h btn=%b",
                 name, i, q_data[i], q_btn[i], bytes[i], exp_btn(bytes[i]));
      end
    end
  endtask

  task automatic test_back_to_back();
    test_bytes("b2b", '{8'h3E, 8'h3C, 8'h52});
  endtask

  task automatic test_glitch();
    clear_mon();
    uart_rx = 1'b0;
    repeat (100) @(negedge clk);
    idle(2 * CPB);
    n_cmp++;
    if (q_data.size() != 0 || ferr_cnt != 0 || stray_cnt != 0) begin
      n_bad++;
      $display("FAIL glitch_reject: got valid=%0d ferr=%0d stray=%0d want 0/0/0",
               q_data.size(), ferr_cnt, stray_cnt);
    end
    test_bytes("glitch_after", '{8'h2D});
  endtask

  task automatic test_frame_error();
    int t;
    clear_mon();
    send_frame(8'h2B, 1'b0, t);
    repeat (5000) @(negedge clk);
    idle(CPB);
    n_cmp++;
    if (ferr_cnt != 1 || q_data.size() != 0 || stray_cnt != 0) begin
      n_bad++;
      $display("FAIL ferr_count: got ferr=%0d valid=%0d stray=%0d want 1/0/0",
               ferr_cnt, q_data.size(), stray_cnt);
    end
    n_cmp++;
    if (rx_data !== last_good) begin
      n_bad++;
      $display("FAIL ferr_data_hold: got %h want %h", rx_data, last_good);
    end
    test_bytes("ferr_after", '{8'h72});
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'hA5;
    clear_mon();
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = b[4];
    repeat (HALF) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rx_data, rx_valid, frame_err, b_p1, b_p5, b_m1, b_m5, b_rst} !== 15'h0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got data=%h v=%b fe=%b btn=%b%b%b%b%b want all 0",
               rx_data, rx_valid, frame_err, b_rst, b_m5, b_m1, b_p5, b_p1);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    last_good = 8'h00;
    idle(2 * CPB);
    n_cmp++;
    if (q_data.size() != 0 || ferr_cnt != 0 || stray_cnt != 0 || rx_data !== 8'h00) begin
      n_bad++;
      $display("FAIL midreset_quiet: got valid=%0d ferr=%0d stray=%0d data=%h want 0/0/0/00",
               q_data.size(), ferr_cnt, stray_cnt, rx_data);
    end
    test_bytes("midreset_after", '{8'h3C});
  endtask

  task automatic test_unknown();
    test_bytes("unknown", '{8'h78});
  endtask

  task automatic test_random();
    logic [7:0] cmds[6];
    logic [7:0] bytes[$];
    cmds = '{8'h2B, 8'h3E, 8'h2D, 8'h3C, 8'h52, 8'h72};
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 1) == 1) bytes.push_back(cmds[$urandom_range(0, 5)]);
      else                           bytes.push_back(8'($urandom_range(0, 255)));
    end
    test_bytes("random", bytes);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    test_unknown();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
